// File: rtl/common_pkg.sv
// Shared types and widths for the bus blocks.
//   DATA_WIDTH  : default data bus width in bits
//   state_t     : generic run-state encoding used by other blocks
//   rsp_state_t : responder FSM states (RspIdle, RspBusy, RspResp)
package common_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_t;

  typedef enum logic [1:0] {
    RspIdle,
    RspBusy,
    RspResp
  } rsp_state_t;

endpackage

// File: rtl/bus_responder_if.sv
// Request/response bus between an initiator and bus_responder.
//   master : initiator side (drives req_*, rsp_ready)
//   slave  : responder side (drives req_ready, rsp_*)
interface bus_responder_if
  import common_pkg::*;
#(
  parameter int DATA_WIDTH = common_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;
  logic [15:0]             rsp_count;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_count
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_count
  );
endinterface

// File: rtl/bus_responder_mem.sv
// Word storage for bus_responder: DEPTH x DATA_WIDTH, byte-enabled
// synchronous write, combinational read, all words cleared on reset.
//   clk, rst_n : clock, async active-low reset
//   we, be     : write strobe and byte enables
//   idx        : word index shared by read and write
//   wdata      : write data
//   rdata      : word at idx (combinational)
module bus_responder_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [IDX_W-1:0]        idx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[idx];
endmodule

// File: rtl/bus_responder.sv
// Single-outstanding request responder with fixed response latency.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of bus_responder_if (request in, response out)
//
// state   | meaning
// RspIdle | ready for a request (req_ready=1)
// RspBusy | request taken, latency counter running down
// RspResp | response presented, waiting for rsp_ready
module bus_responder
  import common_pkg::*;
#(
  parameter int DATA_WIDTH = common_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int LATENCY    = 2
) (
  input logic             clk,
  input logic             rst_n,
  bus_responder_if.slave  bus
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFFS  = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'((1 << OFFS) - 1);
  localparam logic [31:0] DEPTH_U = DEPTH;

  rsp_state_t            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [15:0]           count_q, count_d;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  dec_err;
  logic                  accept;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign word_idx = bus.req_addr >> OFFS;
  assign dec_err  = (32'(word_idx) >= DEPTH_U) || ((bus.req_addr & OFFS_MASK) != '0);
  assign accept   = bus.req_valid && bus.req_ready;
  assign mem_we   = accept && bus.req_we && !dec_err;

  bus_responder_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .idx   (word_idx[IDX_W-1:0]),
    .wdata (bus.req_wdata),
    .be    (bus.req_be),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RspIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    count_d = count_q;
    case (state_q)
      RspIdle: begin
        if (accept) begin
          state_d = RspBusy;
          cnt_d   = 4'(LATENCY - 1);
          err_d   = dec_err;
          // Writes and errored reads answer with zero data.
          rdata_d = (!bus.req_we && !dec_err) ? mem_rdata : '0;
        end
      end
      RspBusy: begin
        if (cnt_q == '0) state_d = RspResp;
        else             cnt_d   = cnt_q - 4'd1;
      end
      RspResp: begin
        if (bus.rsp_ready) begin
          state_d = RspIdle;
          count_d = count_q + 16'd1;
        end
      end
      default: state_d = RspIdle;
    endcase
  end

  // req_ready is gated by rst_n so it stays low while reset is held.
  assign bus.req_ready = rst_n && (state_q == RspIdle);
  assign bus.rsp_valid = (state_q == RspResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_count = count_q;
endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default common_pkg::DATA_WIDTH (32): data bus width in bits, multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: byte-address width.
REQ-003 SHALL have parameter DEPTH, default 16: number of DATA_WIDTH-bit storage words.
REQ-004 SHALL have parameter LATENCY, default 2: cycles spent in Busy, legal range 1..15.
REQ-005 SHALL have ports:
  clk  in  1  clock, all logic on rising edge
  rst_n  in  1  reset, asynchronous, active-low
  req_valid  in  1  initiator request valid
  req_ready  out  1  responder accepts request
  req_we  in  1  1 = write, 0 = read
  req_addr  in  ADDR_WIDTH  byte address
  req_wdata  in  DATA_WIDTH  write data
  req_be  in  DATA_WIDTH/8  write byte enables
  rsp_valid  out  1  response valid
  rsp_ready  in  1  initiator accepts response
  rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
  rsp_err  out  1  decode or alignment error
  rsp_count  out  16  completed-response counter

Function
REQ-006 SHALL implement FSM rsp_state_t with states RspIdle, RspBusy and RspResp.
REQ-007 req_ready SHALL be 1 only in RspIdle: one outstanding request maximum.
REQ-008 Acceptance SHALL occur on the edge where req_valid && req_ready; the FSM goes RspIdle -> RspBusy and the latency counter loads LATENCY-1.
REQ-009 Word index SHALL be req_addr >> log2(DATA_WIDTH/8).
REQ-010 Error SHALL be set if word index >= DEPTH or the low log2(DATA_WIDTH/8) address bits are nonzero.
REQ-011 Write without error SHALL update only enabled bytes of the word at the acceptance edge; a write with error SHALL leave storage unchanged.
REQ-012 Read SHALL capture the word at the acceptance edge into the response register; an error read SHALL capture 0.
REQ-013 RspBusy SHALL decrement the counter each cycle and go to RspResp when the counter is 0, so rsp_valid rises exactly LATENCY cycles after acceptance.
REQ-014 RspResp SHALL hold rsp_valid=1, rsp_rdata and rsp_err stable until rsp_ready=1.
REQ-015 On the rsp_valid && rsp_ready edge the FSM SHALL return to RspIdle, rsp_count SHALL increment (wrap 0xFFFF -> 0x0000) and req_ready SHALL be 1 the next cycle.
REQ-016 A request presented while req_ready=0 SHALL be ignored, and the initiator SHALL hold it; rsp_ready outside RspResp SHALL have no effect.
REQ-017 req_we, req_addr, req_wdata and req_be SHALL be sampled only at acceptance; later changes SHALL not affect the response.
REQ-018 All outputs SHALL be registered or decoded from state only, with no combinational path from req_* or rsp_ready to any output.

Reset
REQ-019 Asserting rst_n=0 SHALL asynchronously force RspIdle, the latency counter to 0, all storage words to 0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and rsp_count=0.
REQ-020 req_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after deassertion.
REQ-021 Reset in RspBusy or RspResp SHALL drop the pending response with no partial handshake; a write accepted before reset SHALL be cleared by the storage reset.

Structure
REQ-022 rsp_state_t (RspIdle, RspBusy, RspResp) SHALL be added to common_pkg alongside state_t, and DATA_WIDTH SHALL come from common_pkg.
REQ-023 Storage SHALL be a sub-module bus_responder_mem: DEPTH x DATA_WIDTH with byte-enabled synchronous write, combinational read and async reset.
REQ-024 The FSM, latency counter, address decode and response register SHALL reside in bus_responder.

Verification
REQ-025 Write addr 0x04, wdata 0xDEADBEEF, be 0xF, then read addr 0x04 -> read rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 2 cycles after acceptance.
REQ-026 Write addr 0x08 0x11223344 be 0xF, then write 0x08 0xAABBCCDD be 0x5, read 0x08 -> 0x11BB33DD.
REQ-027 Read addr 0x40 (index 16) and read addr 0x05 (misaligned) -> rsp_err=1, rsp_rdata=0, storage unchanged.
REQ-028 Hold rsp_ready=0 for 5 cycles in RspResp -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0 throughout; a req_valid pulse meanwhile is not accepted.
REQ-029 Assert rst_n=0 mid-RspBusy after a write -> all outputs 0 immediately; after release, read of that address -> 0 and rsp_count=1.
REQ-030 Preload rsp_count to 0xFFFF via 65535 reads, then one more read -> rsp_count wraps to 0x0000.
